branch_resolve_unit: RTL and testbench

Registered branch resolution stage for the pipelined processor, and the parametrised successor of the combinational branch-address adder. It computes the branch target from the next-instruction address and a sign-extended offset. It evaluates the branch condition and produces a one-cycle-latency redirect decision with valid/stall/flush control. An optional pattern history table (PHT) of 2-bit saturating counters supplies a taken prediction and flags mispredictions.

---
 rtl/branch_pkg.sv | 23 ++
 rtl/branch_resolve_unit_if.sv | 30 +++
 rtl/branch_resolve_unit_pht.sv | 28 ++
 rtl/branch_resolve_unit.sv | 109 ++++++++++
 tb/tb_branch_resolve_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolution stage and its pattern history table.
package branch_pkg;

  typedef enum logic [1:0] {
    BR_BEQ  = 2'b00,
    BR_BNE  = 2'b01,
    BR_JMP  = 2'b10,
    BR_NONE = 2'b11
  } br_type_t;

  typedef logic [1:0] ctr_t;

  localparam ctr_t PHT_RESET_VAL = 2'b01;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Operand, control and result signals of the branch resolution stage.
// Operands are sampled when in_valid & ~stall & ~flush; results appear one cycle later qualified by out_valid.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] next_instr;
  logic [XLEN-1:0] sign_ext_offset;
  logic [1:0]      br_type;
  logic [XLEN-1:0] rs_a;
  logic [XLEN-1:0] rs_b;
  logic            pred_taken;
  logic            out_valid;
  logic [XLEN-1:0] branch_address;
  logic            taken;
  logic [XLEN-1:0] redirect_pc;
  logic            mispredict;

  modport master (
    output in_valid, stall, flush, next_instr, sign_ext_offset, br_type, rs_a, rs_b,
    input  pred_taken, out_valid, branch_address, taken, redirect_pc, mispredict
  );

  modport slave (
    input  in_valid, stall, flush, next_instr, sign_ext_offset, br_type, rs_a, rs_b,
    output pred_taken, out_valid, branch_address, taken, redirect_pc, mispredict
  );
endinterface

// File: rtl/branch_resolve_unit_pht.sv
// Pattern history table of 2-bit saturating counters: combinational read, synchronous write.
// A read and write of the same entry in one cycle returns the pre-update counter.
module branch_pht
  import branch_pkg::*;
#(
  parameter int PHT_DEPTH = 16,
  parameter int IDX_W     = $clog2(PHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  ctr_t mem [PHT_DEPTH];

  assign rd_ctr = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) mem[i] <= PHT_RESET_VAL;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_taken ? sat_inc(mem[wr_idx]) : sat_dec(mem[wr_idx]);
    end
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution: target add, condition evaluation, redirect and mispredict flag.
// Define BRANCH_PRED_EN to add a PHT-based prediction; otherwise prediction is static not-taken (JMP taken).
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int OFFSET_SHIFT = 0,
  parameter int PHT_DEPTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);
  if (PHT_DEPTH < 2 || (PHT_DEPTH & (PHT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("PHT_DEPTH must be a power of two and at least 2");
  end

  br_type_t        typ;
  logic            accept;
  logic            dir;
  logic            pred;
  logic [XLEN-1:0] shifted_offset;
  logic [XLEN-1:0] target;

  logic            valid_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] next_q;
  logic            taken_q;
  logic            pred_q;

  assign typ            = br_type_t'(bus.br_type);
  assign accept         = bus.in_valid & ~bus.stall & ~bus.flush;
  assign shifted_offset = bus.sign_ext_offset << OFFSET_SHIFT;
  assign target         = bus.next_instr + shifted_offset;

  always_comb begin
    dir = 1'b0;
    case (typ)
      BR_BEQ:  dir = (bus.rs_a == bus.rs_b);
      BR_BNE:  dir = (bus.rs_a != bus.rs_b);
      BR_JMP:  dir = 1'b1;
      default: dir = 1'b0;
    endcase
  end

`ifdef BRANCH_PRED_EN
  localparam int IDX_W = $clog2(PHT_DEPTH);
  logic [IDX_W-1:0] pht_idx;
  ctr_t             pht_ctr;
  logic             pht_upd;

  // PC+4 is word aligned, so the index skips the two byte-offset bits.
  assign pht_idx = bus.next_instr[IDX_W+1:2];
  assign pht_upd = accept & (typ == BR_BEQ || typ == BR_BNE);

  branch_pht #(.PHT_DEPTH(PHT_DEPTH)) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pht_idx),
    .rd_ctr   (pht_ctr),
    .wr_en    (pht_upd),
    .wr_idx   (pht_idx),
    .wr_taken (dir)
  );

  always_comb begin
    pred = 1'b0;
    case (typ)
      BR_JMP:  pred = 1'b1;
      BR_NONE: pred = 1'b0;
      default: pred = pht_ctr[1];
    endcase
  end
`else
  always_comb begin
    pred = (typ == BR_JMP);
  end
`endif

  // Priority: reset, flush, stall, accept, idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      next_q  <= '0;
      taken_q <= 1'b0;
      pred_q  <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (bus.stall) begin
      valid_q <= valid_q;
    end else if (accept) begin
      valid_q <= 1'b1;
      addr_q  <= target;
      next_q  <= bus.next_instr;
      taken_q <= dir;
      pred_q  <= pred;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.pred_taken     = pred;
  assign bus.out_valid      = valid_q;
  assign bus.branch_address = addr_q;
  assign bus.taken          = taken_q;
  assign bus.redirect_pc    = taken_q ? addr_q : next_q;
  assign bus.mispredict     = valid_q & (taken_q != pred_q);
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: two instances (OFFSET_SHIFT 0 and 2) driven identically,
// compared against a cycle-level model; PHT training directed tests under BRANCH_PRED_EN.
module tb_branch_resolve_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            s_valid, s_stall, s_flush;
  logic [XLEN-1:0] s_next, s_off, s_a, s_b;
  logic [1:0]      s_type;

  branch_resolve_unit_if #(.XLEN(XLEN)) bus0 ();
  branch_resolve_unit_if #(.XLEN(XLEN)) bus2 ();

  assign bus0.in_valid = s_valid;         assign bus2.in_valid = s_valid;
  assign bus0.stall = s_stall;            assign bus2.stall = s_stall;
  assign bus0.flush = s_flush;            assign bus2.flush = s_flush;
  assign bus0.next_instr = s_next;        assign bus2.next_instr = s_next;
  assign bus0.sign_ext_offset = s_off;    assign bus2.sign_ext_offset = s_off;
  assign bus0.br_type = s_type;           assign bus2.br_type = s_type;
  assign bus0.rs_a = s_a;                 assign bus2.rs_a = s_a;
  assign bus0.rs_b = s_b;                 assign bus2.rs_b = s_b;

  branch_resolve_unit #(.XLEN(XLEN), .OFFSET_SHIFT(0), .PHT_DEPTH(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  branch_resolve_unit #(.XLEN(XLEN), .OFFSET_SHIFT(2), .PHT_DEPTH(16)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int passed = 0;

  // Model state per instance (index 0: shift 0, index 1: shift 2).
  logic            m_valid [2];
  logic [XLEN-1:0] m_addr  [2];
  logic [XLEN-1:0] m_next  [2];
  logic            m_taken [2];
  logic            m_pred  [2];
  int              m_pht   [16];

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    else passed++;
  endtask

  function automatic logic model_dir(input logic [1:0] t, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (t == 2'd0) return a == b;
    if (t == 2'd1) return a != b;
    return t == 2'd2;
  endfunction

  function automatic logic model_pred(input logic [1:0] t, input logic [XLEN-1:0] nxt);
    if (t == 2'd2) return 1'b1;
    if (t == 2'd3) return 1'b0;
`ifdef BRANCH_PRED_EN
    return m_pht[(nxt >> 2) % 16] >= 2;
`else
    return (nxt == nxt) && 1'b0;
`endif
  endfunction

  task automatic drive(input logic v, input logic st, input logic fl, input logic [XLEN-1:0] nxt,
                       input logic [XLEN-1:0] off, input logic [1:0] t,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    s_valid = v; s_stall = st; s_flush = fl; s_next = nxt; s_off = off; s_type = t; s_a = a; s_b = b;
  endtask

  task automatic check_outputs(input int k, input logic was_rst);
    logic            ov, tk, mp;
    logic [XLEN-1:0] ba, rp;
    if (k == 0) begin
      ov = bus0.out_valid; tk = bus0.taken; mp = bus0.mispredict; ba = bus0.branch_address; rp = bus0.redirect_pc;
    end else begin
      ov = bus2.out_valid; tk = bus2.taken; mp = bus2.mispredict; ba = bus2.branch_address; rp = bus2.redirect_pc;
    end
    check_eq("out_valid", {31'b0, ov}, {31'b0, m_valid[k]});
    if (was_rst) begin
      check_eq("rst_addr", ba, 0);
      check_eq("rst_taken", {31'b0, tk}, 0);
      check_eq("rst_redirect", rp, 0);
      check_eq("rst_mispredict", {31'b0, mp}, 0);
    end else if (m_valid[k]) begin
      check_eq("branch_address", ba, m_addr[k]);
      check_eq("taken", {31'b0, tk}, {31'b0, m_taken[k]});
      check_eq("redirect_pc", rp, m_taken[k] ? m_addr[k] : m_next[k]);
      check_eq("mispredict", {31'b0, mp}, {31'b0, m_taken[k] != m_pred[k]});
    end else begin
      check_eq("mispredict_idle", {31'b0, mp}, 0);
    end
  endtask

  // One clock: check the combinational prediction, advance the model at the edge, check registers.
  task automatic cycle();
    logic pd, dir, acc;
    @(negedge clk);
    pd  = model_pred(s_type, s_next);
    dir = model_dir(s_type, s_a, s_b);
    acc = s_valid & ~s_stall & ~s_flush;
    check_eq("pred_taken0", {31'b0, bus0.pred_taken}, {31'b0, pd});
    check_eq("pred_taken2", {31'b0, bus2.pred_taken}, {31'b0, pd});
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_valid[k] = 0; m_addr[k] = 0; m_next[k] = 0; m_taken[k] = 0; m_pred[k] = 0;
      end else if (s_flush) m_valid[k] = 0;
      else if (s_stall) m_valid[k] = m_valid[k];
      else if (acc) begin
        m_valid[k] = 1;
        m_addr[k]  = s_next + (s_off << (2 * k));
        m_next[k]  = s_next;
        m_taken[k] = dir;
        m_pred[k]  = pd;
      end else m_valid[k] = 0;
    end
    if (rst) for (int i = 0; i < 16; i++) m_pht[i] = 1;
    else if (acc && s_type < 2) begin
      int idx = int'((s_next >> 2) % 16);
      m_pht[idx] = dir ? ((m_pht[idx] == 3) ? 3 : m_pht[idx] + 1) : ((m_pht[idx] == 0) ? 0 : m_pht[idx] - 1);
    end
    #1;
    check_outputs(0, rst);
    check_outputs(1, rst);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 2'd3, 0, 0);
    cycle();
    cycle();
    rst = 1'b0;

    // Test-plan targets with literal expectations.
    drive(1, 0, 0, 100, 512, 2'd0, 7, 7);
    cycle();
    check_eq("tp_addr612", bus0.branch_address, 612);
    check_eq("tp_taken612", {31'b0, bus0.taken}, 1);
    check_eq("tp_redirect612", bus0.redirect_pc, 612);
    drive(1, 0, 0, 100, 32'hFFFF_FFF0, 2'd1, 9, 9);
    cycle();
    check_eq("tp_addr36", bus2.branch_address, 36);
    check_eq("tp_taken36", {31'b0, bus2.taken}, 0);
    check_eq("tp_redirect100", bus2.redirect_pc, 100);
    drive(1, 0, 0, 32'hFFFF_FFFC, 2, 2'd0, 1, 2);
    cycle();
    check_eq("tp_wrap4", bus2.branch_address, 4);

    // Static/PHT direction cases: JMP never mispredicts, NONE never taken.
    drive(1, 0, 0, 200, 8, 2'd2, 0, 1);
    cycle();
    check_eq("jmp_mispredict", {31'b0, bus0.mispredict}, 0);
    drive(1, 0, 0, 204, 8, 2'd3, 3, 3);
    cycle();
    check_eq("none_taken", {31'b0, bus0.taken}, 0);

    // Stall holds, flush kills, reset mid-stall clears.
    drive(1, 0, 0, 300, 40, 2'd2, 0, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, $urandom, $urandom, 2'($urandom_range(0, 3)), 0, 0);
      cycle();
      check_eq("stall_hold_addr", bus0.branch_address, 340);
    end
    drive(1, 0, 1, 400, 4, 2'd2, 0, 0);
    cycle();
    check_eq("flush_valid", {31'b0, bus0.out_valid}, 0);
    drive(1, 0, 0, 500, 4, 2'd2, 0, 0);
    cycle();
    drive(1, 1, 0, 600, 4, 2'd2, 0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;

`ifdef BRANCH_PRED_EN
    // Train index 5, then saturate up and down.
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 20, 4, 2'd0, 1, 1); cycle(); end
    drive(1, 0, 0, 20, 4, 2'd0, 1, 2); cycle();
    for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 84, 4, 2'd0, 1, 1); cycle(); end
    for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 84, 4, 2'd0, 1, 2); cycle(); end
`endif

    // Randomised traffic; a small address/operand set forces PHT aliasing and equal operands.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0,
            XLEN'($urandom_range(0, 31)) << 2 | (($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 0),
            $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3));
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
